// File: rtl/pe_start_token_consumer.sv
// Start-token FIFO read port driving the ap_start/ap_ready/ap_done handshake of one PE,
// with a credit limit on invocations that are started but not yet done.
module pe_start_token_consumer #(
  parameter int unsigned DATA_WIDTH      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_WIDTH       = 16,
  localparam int unsigned OUT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  if_empty_n,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_read,
  output logic                  pe_ap_start,
  output logic [DATA_WIDTH-1:0] pe_token,
  input  logic                  pe_ap_ready,
  input  logic                  pe_ap_done,
  output logic [OUT_WIDTH-1:0]  outstanding,
  output logic [CNT_WIDTH-1:0]  launch_cnt,
  output logic [CNT_WIDTH-1:0]  done_cnt,
  output logic                  all_idle,
  output logic                  err_underflow
);

  typedef enum logic [0:0] {StIdle, StStart} state_e;

  localparam logic [OUT_WIDTH:0] MaxOutW = (OUT_WIDTH + 1)'(MAX_OUTSTANDING);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] token_q, token_d;
  logic [OUT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]  launch_cnt_q, done_cnt_q;
  logic                  err_q, err_d;

  logic                  launch;
  logic                  credit_ok;
  logic [OUT_WIDTH:0]    credit_sum;

  assign launch     = (state_q == StStart) & pe_ap_ready;
  // A same-cycle done pulse is deliberately not counted as returned credit.
  assign credit_sum = {1'b0, outstanding_q} + {{OUT_WIDTH{1'b0}}, launch};
  assign credit_ok  = credit_sum < MaxOutW;

  always_comb begin
    if_read = 1'b0;
    state_d = state_q;
    token_d = token_q;
    if (!ap_rst && if_empty_n && credit_ok && ((state_q == StIdle) || launch)) begin
      if_read = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (if_read) begin
          state_d = StStart;
          token_d = if_dout;
        end
      end
      StStart: begin
        if (launch) begin
          if (if_read) begin
            token_d = if_dout;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (launch && !pe_ap_done) begin
      outstanding_d = outstanding_q + OUT_WIDTH'(1);
    end else if (!launch && pe_ap_done) begin
      if (outstanding_q == '0) begin
        err_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - OUT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= StIdle;
      token_q       <= '0;
      outstanding_q <= '0;
      launch_cnt_q  <= '0;
      done_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      token_q       <= token_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      if (launch) begin
        launch_cnt_q <= launch_cnt_q + CNT_WIDTH'(1);
      end
      if (pe_ap_done) begin
        done_cnt_q <= done_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign pe_ap_start   = (state_q == StStart);
  assign pe_token      = token_q;
  assign outstanding   = outstanding_q;
  assign launch_cnt    = launch_cnt_q;
  assign done_cnt      = done_cnt_q;
  assign err_underflow = err_q;
  assign all_idle      = (state_q == StIdle) & ~if_empty_n & (outstanding_q == '0);

endmodule

// File: tb/tb_pe_start_token_consumer.sv
// Bench for pe_start_token_consumer: directed scenarios plus random traffic, all checked
// every cycle against a queue-and-counter model of the start handshake.
module tb_pe_start_token_consumer;

  localparam int unsigned DW   = 8;
  localparam int unsigned MAXO = 2;
  localparam int unsigned CW   = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          if_empty_n;
  logic [DW-1:0] if_dout;
  logic          if_read;
  logic          pe_ap_start;
  logic [DW-1:0] pe_token;
  logic          pe_ap_ready;
  logic          pe_ap_done;
  logic [1:0]    outstanding;
  logic [CW-1:0] launch_cnt;
  logic [CW-1:0] done_cnt;
  logic          all_idle;
  logic          err_underflow;

  always #5 ap_clk = ~ap_clk;

  pe_start_token_consumer #(
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO),
    .CNT_WIDTH       (CW)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .if_empty_n    (if_empty_n),
    .if_dout       (if_dout),
    .if_read       (if_read),
    .pe_ap_start   (pe_ap_start),
    .pe_token      (pe_token),
    .pe_ap_ready   (pe_ap_ready),
    .pe_ap_done    (pe_ap_done),
    .outstanding   (outstanding),
    .launch_cnt    (launch_cnt),
    .done_cnt      (done_cnt),
    .all_idle      (all_idle),
    .err_underflow (err_underflow)
  );

  // Environment FIFO and abstract model: a start is pending or not, plus counts.
  logic [DW-1:0] fifo_q[$];
  bit            m_pending;
  logic [DW-1:0] m_tok;
  int            m_inflight, m_launches, m_dones;
  bit            m_err;
  int            n_cmp, n_fail;
  int            rd_seen, st_seen;
  int            lc0, dc0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending  = 0;
    m_tok      = '0;
    m_inflight = 0;
    m_launches = 0;
    m_dones    = 0;
    m_err      = 0;
  endtask

  task automatic cycle();
    bit accept, exp_read, rd_now;
    if_empty_n = (fifo_q.size() != 0);
    if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    @(negedge ap_clk);
    accept   = m_pending && pe_ap_ready;
    exp_read = !ap_rst && (fifo_q.size() != 0) && (m_inflight + int'(accept) < int'(MAXO))
               && (!m_pending || accept);
    check("if_read", 32'(if_read), 32'(exp_read));
    check("pe_ap_start", 32'(pe_ap_start), 32'(m_pending));
    check("pe_token", 32'(pe_token), 32'(m_tok));
    check("outstanding", 32'(outstanding), 32'(m_inflight));
    check("launch_cnt", 32'(launch_cnt), 32'(m_launches % 16));
    check("done_cnt", 32'(done_cnt), 32'(m_dones % 16));
    check("all_idle", 32'(all_idle), 32'(!m_pending && fifo_q.size() == 0 && m_inflight == 0));
    check("err_underflow", 32'(err_underflow), 32'(m_err));
    rd_now = (if_read === 1'b1);
    if (rd_now) rd_seen++;
    if (pe_ap_start === 1'b1) st_seen++;
    @(posedge ap_clk);
    if (ap_rst) begin
      model_reset();
    end else begin
      if (accept) m_launches++;
      if (pe_ap_done) begin
        m_dones++;
        if (m_inflight == 0 && !accept) m_err = 1;
      end
      if (accept && !pe_ap_done) m_inflight++;
      else if (!accept && pe_ap_done && m_inflight > 0) m_inflight--;
      if (exp_read) begin
        m_pending = 1;
        m_tok     = fifo_q[0];
      end else if (accept) begin
        m_pending = 0;
      end
    end
    if (rd_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    ap_rst = 1'b1;
    pe_ap_ready = 1'b0;
    pe_ap_done = 1'b0;
    if_empty_n = 1'b0;
    if_dout = '0;
    model_reset();
    @(posedge ap_clk);
    #1;
    cycles(2);
    ap_rst = 1'b0;
    cycle();
    check("reset_all_idle", 32'(all_idle), 32'd1);

    // Single token, PE ready after 3 cycles, done 5 cycles after launch.
    rd_seen = 0;
    st_seen = 0;
    fifo_q.push_back(8'd1);
    cycle();
    cycles(3);
    pe_ap_ready = 1'b1;
    cycle();
    pe_ap_ready = 1'b0;
    cycles(4);
    pe_ap_done = 1'b1;
    cycle();
    pe_ap_done = 1'b0;
    cycles(2);
    check("t1_reads", 32'(rd_seen), 32'd1);
    check("t1_start_cycles", 32'(st_seen), 32'd4);
    check("t1_launch_cnt", 32'(launch_cnt), 32'd1);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_all_idle", 32'(all_idle), 32'd1);

    // Four tokens, ready held, no done: credit limit stops at two launches.
    rd_seen = 0;
    st_seen = 0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'hA0 + i));
    pe_ap_ready = 1'b1;
    cycles(6);
    check("t2_reads", 32'(rd_seen), 32'd2);
    check("t2_starts", 32'(st_seen), 32'd2);
    check("t2_outstanding", 32'(outstanding), 32'd2);
    check("t2_fifo_left", 32'(fifo_q.size()), 32'd2);
    check("t2_start_low", 32'(pe_ap_start), 32'd0);
    rd_seen = 0;
    pe_ap_done = 1'b1;
    cycle();
    pe_ap_done = 1'b0;
    cycles(3);
    check("t2_one_more_read", 32'(rd_seen), 32'd1);
    check("t2_outstanding_again", 32'(outstanding), 32'd2);

    // Launch and done together at outstanding=1.
    pe_ap_ready = 1'b0;
    pe_ap_done = 1'b1;
    cycle();
    pe_ap_done = 1'b0;
    cycle();
    lc0 = int'(launch_cnt);
    dc0 = int'(done_cnt);
    pe_ap_ready = 1'b1;
    pe_ap_done = 1'b1;
    cycle();
    check("t3_outstanding", 32'(outstanding), 32'd1);
    check("t3_launch_inc", 32'(launch_cnt), 32'((lc0 + 1) % 16));
    check("t3_done_inc", 32'(done_cnt), 32'((dc0 + 1) % 16));
    pe_ap_ready = 1'b0;
    cycle();
    pe_ap_done = 1'b0;
    cycle();

    // Underflow from a fresh reset.
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    pe_ap_done = 1'b1;
    cycle();
    pe_ap_done = 1'b0;
    cycles(3);
    check("t4_err", 32'(err_underflow), 32'd1);
    check("t4_outstanding", 32'(outstanding), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Reset while START waits on ready.
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h3C);
    pe_ap_ready = 1'b1;
    cycles(2);
    pe_ap_ready = 1'b0;
    cycle();
    check("t5_waiting", 32'(pe_ap_start), 32'd1);
    fifo_q.push_back(8'h77);
    rd_seen = 0;
    ap_rst = 1'b1;
    cycle();
    check("t5_start_dropped", 32'(pe_ap_start), 32'd0);
    check("t5_outstanding", 32'(outstanding), 32'd0);
    check("t5_launch_cnt", 32'(launch_cnt), 32'd0);
    check("t5_done_cnt", 32'(done_cnt), 32'd0);
    check("t5_err_cleared", 32'(err_underflow), 32'd0);
    cycle();
    check("t5_no_read_in_reset", 32'(rd_seen), 32'd0);
    fifo_q.delete();
    cycle();
    ap_rst = 1'b0;

    // 17 launch/done pairs wrap the 4-bit counters.
    for (int i = 0; i < 17; i++) begin
      fifo_q.push_back(8'($urandom));
      cycle();
      pe_ap_ready = 1'b1;
      cycle();
      pe_ap_ready = 1'b0;
      pe_ap_done = 1'b1;
      cycle();
      pe_ap_done = 1'b0;
    end
    check("t6_launch_wrap", 32'(launch_cnt), 32'd1);
    check("t6_done_wrap", 32'(done_cnt), 32'd1);
    check("t6_outstanding", 32'(outstanding), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ap_rst = ($urandom_range(0, 99) == 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
      pe_ap_ready = 1'($urandom);
      pe_ap_done = (m_inflight > 0) ? ($urandom_range(0, 2) == 0)
                                    : ($urandom_range(0, 49) == 0);
      cycle();
    end
    ap_rst = 1'b0;
    pe_ap_ready = 1'b0;
    pe_ap_done = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
